pcoeff_batch_accumulator: RTL and testbench

- Sits directly downstream of the streaming connected-count core; consumes its in-order result stream (resultValid, connectCount, extraDataOut) at full clk rate.
- For each valid bot, adds 2^connectCount into a per-top accumulator and counts valid bots.
- A batch-end marker carried in the extra-data field closes the current top's batch. The block then emits {sum, count, error flags} into a 2-entry output buffer with valid/ready handshake.

---
 rtl/pcoeff_batch_accumulator.sv | 175 +++++++++++++++++
 tb/tb_pcoeff_batch_accumulator.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pcoeff_batch_accumulator.sv
// pcoeff_batch_accumulator
// Accumulates 2^connectCount per valid bot and counts valid bots for each top.
// A batchEnd slot closes the batch; the finished record lands in a 2-entry
// FIFO drained with a valid/ready handshake. Pipeline:
//   stage 1: register inputs and the decoded addend
//   stage 2: accumulate, or snapshot the closing record and restart
//   buffer : record becomes visible the cycle after stage 2
module pcoeff_batch_accumulator #(
  parameter int SUM_WIDTH   = 48,
  parameter int COUNT_WIDTH = 35
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   resultValid,
  input  logic [5:0]             connectCount,
  input  logic                   batchEnd,
  input  logic                   eccIn,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [SUM_WIDTH-1:0]   outSum,
  output logic [COUNT_WIDTH-1:0] outCount,
  output logic                   outOverflow,
  output logic                   outEcc,
  output logic                   stallInput,
  output logic                   dropError
);

  localparam int unsigned          SW_U = SUM_WIDTH;
  localparam logic [SUM_WIDTH-1:0] ONE  = {{(SUM_WIDTH-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [SUM_WIDTH-1:0]   sum;
    logic [COUNT_WIDTH-1:0] cnt;
    logic                   ovf;
    logic                   ecc;
  } rec_t;

  // ---------------------------------------------------------------------------
  // Internal reset: asserts immediately with rst, releases two edges later
  // ---------------------------------------------------------------------------
  logic [1:0] r_rst_sync;
  logic       w_rst;

  // reset synchronizer: async assert, clocked release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rst_sync <= 2'b11;
    else     r_rst_sync <= {r_rst_sync[0], 1'b0};
  end

  assign w_rst = r_rst_sync[1];

  // ---------------------------------------------------------------------------
  // Stage 1
  // ---------------------------------------------------------------------------
  logic                 w_in_range;
  logic [SUM_WIDTH-1:0] w_addend;

  // counts at or beyond the accumulator width cannot be represented: they add
  // nothing and flag overflow for the batch instead
  assign w_in_range = ({26'd0, connectCount} < SW_U);
  assign w_addend   = (resultValid && w_in_range) ? (ONE << connectCount) : '0;

  logic                 r_s1_vld, r_s1_end, r_s1_ecc, r_s1_ovf;
  logic [SUM_WIDTH-1:0] r_s1_add;

  // stage-1 capture of the incoming slot
  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_s1_vld <= 1'b0;
      r_s1_end <= 1'b0;
      r_s1_ecc <= 1'b0;
      r_s1_ovf <= 1'b0;
      r_s1_add <= '0;
    end else begin
      r_s1_vld <= resultValid;
      r_s1_end <= batchEnd;
      r_s1_ecc <= eccIn;
      r_s1_ovf <= resultValid && !w_in_range;
      r_s1_add <= w_addend;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2
  // ---------------------------------------------------------------------------
  logic [SUM_WIDTH-1:0]   r_acc;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic                   r_ovf, r_ecc;
  logic [SUM_WIDTH:0]     w_sum_x;
  logic [COUNT_WIDTH:0]   w_cnt_x;
  logic                   w_ovf_n, w_ecc_n;
  rec_t                   r_rec;
  logic                   r_rec_vld;

  // the next-state values already include the current slot, so a closing slot
  // contributes to its own record
  assign w_sum_x = {1'b0, r_acc} + {1'b0, r_s1_add};
  assign w_cnt_x = {1'b0, r_cnt} + {{COUNT_WIDTH{1'b0}}, r_s1_vld};
  assign w_ovf_n = r_ovf | w_sum_x[SUM_WIDTH] | w_cnt_x[COUNT_WIDTH] | r_s1_ovf;
  assign w_ecc_n = r_ecc | r_s1_ecc;

  // accumulate, or snapshot the record and restart from zero on batch close
  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_ecc     <= 1'b0;
      r_rec     <= '0;
      r_rec_vld <= 1'b0;
    end else if (r_s1_end) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_ecc     <= 1'b0;
      r_rec     <= '{sum: w_sum_x[SUM_WIDTH-1:0], cnt: w_cnt_x[COUNT_WIDTH-1:0],
                     ovf: w_ovf_n, ecc: w_ecc_n};
      r_rec_vld <= 1'b1;
    end else begin
      r_acc     <= w_sum_x[SUM_WIDTH-1:0];
      r_cnt     <= w_cnt_x[COUNT_WIDTH-1:0];
      r_ovf     <= w_ovf_n;
      r_ecc     <= w_ecc_n;
      r_rec_vld <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry output FIFO
  // ---------------------------------------------------------------------------
  rec_t       r_mem [2];
  logic       r_wp, r_rp;
  logic [1:0] r_fill;
  logic       r_drop;
  logic       w_pop, w_full, w_wr, w_drop;

  assign w_pop  = (r_fill != 2'd0) && outReady;
  assign w_full = (r_fill == 2'd2);
  // a pop frees the slot in the same edge, so a full buffer still accepts
  assign w_wr   = r_rec_vld && (!w_full || w_pop);
  assign w_drop = r_rec_vld && w_full && !w_pop;

  // FIFO storage, pointers, occupancy and sticky drop flag
  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wp   <= 1'b0;
      r_rp   <= 1'b0;
      r_fill <= 2'd0;
      r_drop <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= r_rec;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      case ({w_wr, w_pop})
        2'b10:   r_fill <= r_fill + 2'd1;
        2'b01:   r_fill <= r_fill - 2'd1;
        default: r_fill <= r_fill;
      endcase
      if (w_drop) r_drop <= 1'b1;
    end
  end

  // head entry is only rewritten on the edge that pops it, keeping it stable
  assign outValid    = (r_fill != 2'd0);
  assign outSum      = r_mem[r_rp].sum;
  assign outCount    = r_mem[r_rp].cnt;
  assign outOverflow = r_mem[r_rp].ovf;
  assign outEcc      = r_mem[r_rp].ecc;
  assign dropError   = r_drop;
  assign stallInput  = (r_fill != 2'd0) || r_s1_end || r_rec_vld;

endmodule

// File: tb/tb_pcoeff_batch_accumulator.sv
// Scoreboard bench for pcoeff_batch_accumulator: the stimulus side updates a
// plain-arithmetic batch model and queues expected records; a monitor pops and
// compares whenever a record is handed over.
module tb_pcoeff_batch_accumulator;

  localparam int SW = 48;
  localparam int CW = 35;

  logic          clk, rst;
  logic          resultValid, batchEnd, eccIn, outReady;
  logic [5:0]    connectCount;
  logic          outValid, outOverflow, outEcc, stallInput, dropError;
  logic [SW-1:0] outSum;
  logic [CW-1:0] outCount;

  pcoeff_batch_accumulator #(.SUM_WIDTH(SW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .resultValid(resultValid), .connectCount(connectCount),
    .batchEnd(batchEnd), .eccIn(eccIn),
    .outValid(outValid), .outReady(outReady),
    .outSum(outSum), .outCount(outCount),
    .outOverflow(outOverflow), .outEcc(outEcc),
    .stallInput(stallInput), .dropError(dropError)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // expected record queues
  longint exp_sum[$];
  longint exp_cnt[$];
  bit     exp_ovf[$];
  bit     exp_ecc[$];

  // batch model: exact sum of powers of two, reduced only when recorded
  longint m_sum;
  longint m_cnt;
  bit     m_big, m_ecc;

  task automatic model_clear();
    m_sum = 0; m_cnt = 0; m_big = 0; m_ecc = 0;
  endtask

  // present one slot for one clock; keep=0 means the record is expected lost
  task automatic slot(input bit v, input int cc, input bit be, input bit e, input bit keep);
    resultValid = v; connectCount = cc[5:0]; batchEnd = be; eccIn = e;
    if (e) m_ecc = 1;
    if (v) begin
      m_cnt++;
      if (cc >= SW) m_big = 1;
      else          m_sum += (64'd1 << cc);
    end
    if (be) begin
      if (keep) begin
        exp_sum.push_back(m_sum % (64'd1 << SW));
        exp_cnt.push_back(m_cnt);
        exp_ovf.push_back(m_big || (m_sum >= (64'd1 << SW)));
        exp_ecc.push_back(m_ecc);
      end
      model_clear();
    end
    @(posedge clk); #1;
    resultValid = 0; connectCount = 0; batchEnd = 0; eccIn = 0;
  endtask

  // consumer: 0 = hold, 1 = always ready, 2 = random
  int mode = 1;
  initial begin
    outReady = 0;
    forever begin
      @(posedge clk); #1;
      case (mode)
        0:       outReady = 0;
        1:       outReady = 1;
        default: outReady = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor: compare each accepted record against the queue head
  always @(negedge clk) begin
    if (!rst && outValid && outReady) begin
      if (exp_sum.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_record: got sum %0d count %0d, expected none", outSum, outCount);
      end else begin
        chk("rec_sum", longint'(outSum),      exp_sum.pop_front());
        chk("rec_cnt", longint'(outCount),    exp_cnt.pop_front());
        chk("rec_ovf", longint'(outOverflow), longint'(exp_ovf.pop_front()));
        chk("rec_ecc", longint'(outEcc),      longint'(exp_ecc.pop_front()));
      end
    end
  end

  task automatic wait_drain(input int lim);
    int n = 0;
    while (exp_sum.size() != 0 && n < lim) begin @(posedge clk); #1; n++; end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_pending", longint'(exp_sum.size()), 0);
  endtask

  task automatic wait_nostall(input int lim);
    int n = 0;
    while (stallInput && n < lim) begin @(posedge clk); #1; n++; end
    if (stallInput) chk("stall_timeout", 1, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1; resultValid = 0; connectCount = 0; batchEnd = 0; eccIn = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outValid",   longint'(outValid),   0);
    chk("rst_outSum",     longint'(outSum),     0);
    chk("rst_outCount",   longint'(outCount),   0);
    chk("rst_stall",      longint'(stallInput), 0);
    chk("rst_dropError",  longint'(dropError),  0);
    rst = 0;
    repeat (4) @(posedge clk);
    #1;

    // counts 0,1,2,5 -> sum 39, count 4; check 3-cycle latency
    mode = 1;
    slot(1, 0, 0, 0, 1); slot(1, 1, 0, 0, 1); slot(1, 2, 0, 0, 1); slot(1, 5, 1, 0, 1);
    chk("lat_c1", longint'(outValid), 0);
    @(posedge clk); #1;
    chk("lat_c2", longint'(outValid), 0);
    @(posedge clk); #1;
    chk("lat_c3", longint'(outValid), 1);
    chk("t1_sum", longint'(outSum), 39);
    chk("t1_cnt", longint'(outCount), 4);
    wait_drain(20);

    // invalid slots carry count 63 and contribute nothing; close on invalid
    slot(1, 3, 0, 0, 1); slot(0, 63, 0, 0, 1); slot(1, 4, 0, 0, 1); slot(0, 63, 1, 0, 1);
    wait_drain(20);

    // overflow: count 48 plus two 2^47; next batch clean
    slot(1, 48, 0, 0, 1); slot(1, 47, 0, 0, 1); slot(1, 47, 1, 0, 1);
    slot(1, 3, 1, 0, 1);
    wait_drain(20);
    // pure carry overflow without out-of-range count
    slot(1, 47, 0, 0, 1); slot(1, 47, 0, 0, 1); slot(1, 0, 1, 0, 1);
    wait_drain(20);

    // batchEnd every cycle with consumer always ready
    for (int i = 0; i < 8; i++) slot(1, i * 3, 1, 0, 1);
    wait_drain(30);
    chk("b2b_noDrop", longint'(dropError), 0);

    // randomized batches, upstream honours stallInput, random consumer
    mode = 2;
    for (int b = 0; b < 25; b++) begin
      int n;
      wait_nostall(100);
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        bit v, e;
        int cc;
        v  = ($urandom % 4) != 0;
        cc = (($urandom % 8) == 0) ? $urandom_range(40, 63) : $urandom_range(0, 20);
        e  = ($urandom % 10) == 0;
        slot(v, cc, j == n - 1, e, 1);
      end
    end
    wait_drain(200);
    chk("rand_noDrop", longint'(dropError), 0);

    // three back-to-back batches into a held consumer: third is dropped
    mode = 0;
    repeat (2) @(posedge clk);
    #1;
    slot(1, 1, 1, 0, 1);
    chk("drop_stall_early", longint'(stallInput), 1);
    slot(1, 2, 1, 0, 1);
    slot(1, 3, 1, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("drop_flag",   longint'(dropError),  1);
    chk("drop_stall",  longint'(stallInput), 1);
    chk("drop_valid",  longint'(outValid),   1);
    chk("drop_head",   longint'(outSum),     2);
    mode = 1;
    wait_drain(20);
    chk("drop_sticky", longint'(dropError),  1);

    // ecc pulse mid-batch that closes normally
    slot(1, 1, 0, 0, 1); slot(1, 2, 0, 1, 1); slot(1, 3, 1, 0, 1);
    wait_drain(20);

    // ecc pulse then reset mid-batch: partial batch discarded, flags cleared
    slot(1, 2, 0, 1, 1); slot(1, 3, 0, 0, 1);
    rst = 1;
    #1;
    model_clear();
    chk("mrst_valid", longint'(outValid),   0);
    chk("mrst_sum",   longint'(outSum),     0);
    chk("mrst_cnt",   longint'(outCount),   0);
    chk("mrst_drop",  longint'(dropError),  0);
    chk("mrst_stall", longint'(stallInput), 0);
    do_reset();
    slot(1, 4, 1, 0, 1);
    wait_drain(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
